// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the program counter, captures the ROM word
// and its PC into a valid/ready IF/ID register, and handles execute redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] program_counter,
    input  logic [31:0] instruction,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction,
    output logic        misalign_pulse,
    output logic [31:0] fetch_count
);

    // The IF/ID register is either empty or holds one valid word.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } if_state_t;

    if_state_t   state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] if_pc_reg, if_pc_next;
    logic [31:0] if_instr_reg, if_instr_next;
    logic        misalign_reg, misalign_next;
    logic [31:0] fetch_count_reg, fetch_count_next;

    logic        consume;
    logic        load;

    // Decode takes the word this cycle; a new fetch fits when the slot frees up.
    assign consume = (state_reg == FULL) && if_ready;
    assign load    = !stall && ((state_reg == EMPTY) || if_ready);

    // State register; reset restores the fetch start point and an empty slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= EMPTY;
            pc_reg          <= RESET_PC;
            if_pc_reg       <= 32'h0000_0000;
            if_instr_reg    <= NOP_INSTR;
            misalign_reg    <= 1'b0;
            fetch_count_reg <= 32'h0000_0000;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            if_pc_reg       <= if_pc_next;
            if_instr_reg    <= if_instr_next;
            misalign_reg    <= misalign_next;
            fetch_count_reg <= fetch_count_next;
        end
    end

    // Next-state: redirect flushes first, then load, then stalled consume drains.
    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        if_pc_next       = if_pc_reg;
        if_instr_next    = if_instr_reg;
        misalign_next    = 1'b0;
        // A consumed word counts even when a redirect flushes the slot.
        fetch_count_next = fetch_count_reg + (consume ? 32'd1 : 32'd0);

        if (redirect_valid) begin
            // Low address bits are dropped; the flag reports that they were set.
            pc_next       = {redirect_pc[31:2], 2'b00};
            state_next    = EMPTY;
            if_instr_next = NOP_INSTR;
            misalign_next = |redirect_pc[1:0];
        end else if (load) begin
            if_pc_next    = pc_reg;
            if_instr_next = instruction;
            state_next    = FULL;
            pc_next       = pc_reg + 32'd4;
        end else if (stall && consume) begin
            state_next    = EMPTY;
            if_instr_next = NOP_INSTR;
        end
    end

    // The ROM is addressed straight from the PC register so it answers this cycle.
    assign program_counter = pc_reg;
    assign if_valid        = (state_reg == FULL);
    assign if_pc           = if_pc_reg;
    assign if_instruction  = if_instr_reg;
    assign misalign_pulse  = misalign_reg;
    assign fetch_count     = fetch_count_reg;

endmodule
